// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam int FETCH_Q_DEPTH = 2;
  localparam int OCC_W = $clog2(FETCH_Q_DEPTH + 1);
  typedef enum logic [1:0] {HOLD, FETCH, DROP} fetch_state_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry {instr, pc} FIFO with registered head, sync flush and occupancy
module fetch_queue
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [31:0]        push_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] head_instr,
  output logic [31:0]        head_pc,
  output logic [OCC_W-1:0]   occ
);
  logic [INSTR_W-1:0] tail_instr;
  logic [31:0]        tail_pc;
  logic [OCC_W-1:0]   occ_d;
  logic               wr_head, wr_tail;
  // a push lands in the head slot when the queue is empty after this cycle's pop
  always_comb begin
    wr_head = push && occ == OCC_W'(pop);
    wr_tail = push && !wr_head;
    occ_d = flush ? '0 : occ + OCC_W'(push) - OCC_W'(pop);
  end
  // head shifts from tail on pop; flush only clears occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
      valid <= 1'b0;
      head_instr <= '0;
      head_pc <= '0;
      tail_instr <= '0;
      tail_pc <= '0;
    end else begin
      occ <= occ_d;
      valid <= occ_d != '0;
      if (wr_head) begin
        head_instr <= push_instr;
        head_pc <= push_pc;
      end else if (pop) begin
        head_instr <= tail_instr;
        head_pc <= tail_pc;
      end
      if (wr_tail) begin
        tail_instr <= push_instr;
        tail_pc <= push_pc;
      end
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n) !(push && occ == OCC_W'(FETCH_Q_DEPTH)));
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC + single-outstanding imem fetch FSM feeding a 2-entry queue; FETCH_PERF_EN adds perf counters
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  input  logic               instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);
  fetch_state_t     state, state_d;
  logic [31:0]      pc, pc_d, addr_d;
  logic             req_d, push, pop, room, busy;
  logic [OCC_W-1:0] occ;
  assign push = state == FETCH && imem_ack && !redirect_valid;
  assign pop = instr_valid && instr_ready;
  assign room = occ + OCC_W'(push) - OCC_W'(pop) <= OCC_W'(FETCH_Q_DEPTH - 1);
  assign busy = state != HOLD && !imem_ack;
  fetch_queue u_queue (
    .clk(clk),
    .rst_n(rst_n),
    .flush(redirect_valid),
    .push(push),
    .pop(pop),
    .push_instr(imem_rdata),
    .push_pc(imem_addr),
    .valid(instr_valid),
    .head_instr(instr),
    .head_pc(instr_pc),
    .occ(occ)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HOLD;
    else state <= state_d;
  end
  // outstanding request waits for ack (redirect turns it into a drop); otherwise fetch if an ack would fit
  always_comb begin
    state_d = busy ? (redirect_valid ? DROP : state) : (redirect_valid || room) ? FETCH : HOLD;
  end
  // next pc / request / address; a dropped request keeps its address while pc already holds the target
  always_comb begin
    pc_d = redirect_valid ? {redirect_pc[31:2], 2'b00} : push ? pc + 32'(PC_STEP) : pc;
    req_d = state_d != HOLD;
    addr_d = state_d == DROP ? imem_addr : pc_d;
  end
  // registered pc and memory request outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      pc <= pc_d;
      imem_req <= req_d;
      imem_addr <= addr_d;
    end
  end
`ifdef FETCH_PERF_EN
  // saturating counts of kept fetches and consumer stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall <= '0;
    end else begin
      perf_fetched <= sat_inc(perf_fetched, push);
      perf_stall <= sat_inc(perf_stall, instr_valid && !instr_ready);
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized bench for instr_fetch against a transaction-level queue model
module tb_instr_fetch;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_ack = 1'b0, redirect_valid = 1'b0, instr_ready = 1'b0;
  logic [31:0] imem_rdata, redirect_pc = '0;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif
  int          n_vec = 0, n_bad = 0;
  logic        exp_req, disc;
  logic [31:0] exp_addr, mpc, exp_fetched, exp_stall;
  logic [63:0] q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  instr_fetch dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall(perf_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_req = 1'b0;
    exp_addr = 32'h0;
    mpc = 32'h0;
    disc = 1'b0;
    exp_fetched = 0;
    exp_stall = 0;
    q.delete();
  endtask

  task automatic check_outputs();
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, exp_addr);
    check("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("instr", instr, q[0][63:32]);
      check("instr_pc", instr_pc, q[0][31:0]);
    end
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, exp_fetched);
    check("perf_stall", perf_stall, exp_stall);
`endif
  endtask

  // one cycle: check at negedge, drive inputs, advance the model by the spec's rules
  task automatic step(input logic a, input logic r, input logic rv, input logic [31:0] rpc);
    logic out, acc, pop;
    check_outputs();
    imem_ack = a && imem_req;
    instr_ready = r;
    redirect_valid = rv;
    redirect_pc = rpc;
    pop = q.size() != 0 && r;
    acc = exp_req && a && !disc && !rv;
    out = exp_req && !a;
    if (q.size() != 0 && !r) exp_stall++;
    if (acc) exp_fetched++;
    if (rv) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back({mem_word(exp_addr), exp_addr});
    end
    mpc = rv ? {rpc[31:2], 2'b00} : acc ? mpc + 32'd4 : mpc;
    disc = out && (disc || rv);
    exp_req = out || q.size() <= 1;
    if (!out) exp_addr = mpc;
    @(negedge clk);
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 7) == 0 ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst imem_req", 32'(imem_req), 32'd0);
    check("rst imem_addr", imem_addr, 32'h0);
    check("rst instr_valid", 32'(instr_valid), 32'd0);
    check("rst instr", instr, 32'h0);
    check("rst instr_pc", instr_pc, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0103);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0040);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0080);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    random_run(3000);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    imem_ack = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    #1;
    check("midrst imem_req", 32'(imem_req), 32'd0);
    check("midrst imem_addr", imem_addr, 32'h0);
    check("midrst instr_valid", 32'(instr_valid), 32'd0);
    check("midrst instr", instr, 32'h0);
    check("midrst instr_pc", instr_pc, 32'h0);
`ifdef FETCH_PERF_EN
    check("midrst perf_fetched", perf_fetched, 32'h0);
    check("midrst perf_stall", perf_stall, 32'h0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    random_run(500);
    check_outputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
